// File: rtl/lcd_panel_model.sv
// Responder model of a dual-chip 128x64 graphic LCD: decodes bus strobes per half,
// holds display RAM and state, and answers status/data reads plus a frame-buffer readback.
module lcd_panel_model #(
  parameter int BUSY_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  graphic_lcd_d,
  input  logic        graphic_lcd_rw,
  input  logic        graphic_lcd_en,
  input  logic        graphic_lcd_di,
  input  logic        graphic_lcd_rst,
  input  logic        graphic_lcd_cs1,
  input  logic        graphic_lcd_cs2,
  output logic [7:0]  lcd_rd_data,
  output logic        lcd_rd_oe,
  input  logic [9:0]  pix_addr,
  output logic [7:0]  pix_data,
  output logic [1:0]  disp_on,
  output logic [5:0]  start_line0,
  output logic [5:0]  start_line1,
  output logic [15:0] wr_count,
  output logic        violation
);

  localparam int BW = $clog2(BUSY_CYCLES + 1);
  localparam logic [BW-1:0] BUSY_LOAD = BW'(BUSY_CYCLES);
  localparam logic [BW-1:0] BUSY_ONE  = BW'(1);
  localparam logic [BW-1:0] BUSY_ZERO = BW'(0);

  typedef enum logic [2:0] {
    OP_NONE, OP_ON, OP_Y, OP_PAGE, OP_START, OP_WDATA, OP_RDATA, OP_STATUS
  } op_e;

  logic        en_r, rw_r, di_r, cs1_r, cs2_r;
  logic [7:0]  d_r;
  op_e         op_s;
  logic        strobe_s, nonstat_s, drop_s, rd_active_s, rd_half_s;
  logic [1:0]  sel_s, busy_s, exec_s;
  logic [1:0][8:0]    addr_s;
  logic [1:0][7:0]    ram_rd_s;
  logic [1:0][5:0]    y_r, start_r;
  logic [1:0][2:0]    page_r;
  logic [1:0]         on_r;
  logic [1:0][BW-1:0] busy_cnt_r;
  logic [1:0][7:0]    latch_r;
  logic [15:0]        wr_count_r;
  logic               violation_r;
  logic [7:0]         status_s;
  logic [7:0]         ram_r [0:1][0:511];

  // Bus capture: en history plus the qualifiers of the last en-high cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      en_r  <= 1'b0;
      d_r   <= 8'h00;
      rw_r  <= 1'b0;
      di_r  <= 1'b0;
      cs1_r <= 1'b0;
      cs2_r <= 1'b0;
    end else begin
      en_r <= graphic_lcd_en;
      if (graphic_lcd_en) begin
        d_r   <= graphic_lcd_d;
        rw_r  <= graphic_lcd_rw;
        di_r  <= graphic_lcd_di;
        cs1_r <= graphic_lcd_cs1;
        cs2_r <= graphic_lcd_cs2;
      end
    end
  end

  // Operation decode of the latched transaction
  always_comb begin
    op_s = OP_NONE;
    case ({rw_r, di_r})
      2'b00: begin
        casez (d_r)
          8'b0011_111?: op_s = OP_ON;
          8'b01??_????: op_s = OP_Y;
          8'b1011_1???: op_s = OP_PAGE;
          8'b11??_????: op_s = OP_START;
          default:      op_s = OP_NONE;
        endcase
      end
      2'b01:   op_s = OP_WDATA;
      2'b10:   op_s = OP_STATUS;
      2'b11:   op_s = OP_RDATA;
      default: op_s = OP_NONE;
    endcase
  end

  // Per-half accept/drop qualification; a busy half drops the op, the other still runs it
  always_comb begin
    strobe_s  = en_r & ~graphic_lcd_en & graphic_lcd_rst;
    sel_s     = {cs2_r, cs1_r};
    nonstat_s = (op_s != OP_NONE) && (op_s != OP_STATUS);
    busy_s    = 2'b00;
    exec_s    = 2'b00;
    for (int h = 0; h < 2; h++) begin
      busy_s[h]   = (busy_cnt_r[h] != BUSY_ZERO);
      addr_s[h]   = {page_r[h], y_r[h]};
      ram_rd_s[h] = ram_r[h][addr_s[h]];
      if (strobe_s && nonstat_s && sel_s[h] && !busy_s[h]) begin
        exec_s[h] = 1'b1;
      end else begin
        exec_s[h] = 1'b0;
      end
    end
    drop_s = strobe_s & nonstat_s & |(sel_s & busy_s);
  end

  // Per-half register state, busy counters and read latches
  always_ff @(posedge clk) begin
    if (rst) begin
      y_r        <= '{default: 6'd0};
      page_r     <= '{default: 3'd0};
      on_r       <= 2'b00;
      start_r    <= '{default: 6'd0};
      busy_cnt_r <= '{default: BUSY_ZERO};
      latch_r    <= '{default: 8'h00};
    end else begin
      for (int h = 0; h < 2; h++) begin
        if (!graphic_lcd_rst) begin
          on_r[h]    <= 1'b0;
          start_r[h] <= 6'd0;
        end
        if (exec_s[h]) begin
          busy_cnt_r[h] <= BUSY_LOAD;
          case (op_s)
            OP_ON:    on_r[h]    <= d_r[0];
            OP_Y:     y_r[h]     <= d_r[5:0];
            OP_PAGE:  page_r[h]  <= d_r[2:0];
            OP_START: start_r[h] <= d_r[5:0];
            OP_WDATA: y_r[h]     <= y_r[h] + 6'd1;
            OP_RDATA: begin
              latch_r[h] <= ram_rd_s[h];
              y_r[h]     <= y_r[h] + 6'd1;
            end
            default: ;
          endcase
        end else if (busy_s[h]) begin
          busy_cnt_r[h] <= busy_cnt_r[h] - BUSY_ONE;
        end
      end
    end
  end

  // Display RAM writes and the registered frame-buffer readback port (never cleared)
  always_ff @(posedge clk) begin
    for (int h = 0; h < 2; h++) begin
      if (!rst && exec_s[h] && (op_s == OP_WDATA)) begin
        ram_r[h][addr_s[h]] <= d_r;
      end
    end
    pix_data <= ram_r[pix_addr[9]][pix_addr[8:0]];
  end

  // Write counter (once per strobe, saturating) and drop pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_r  <= 16'h0000;
      violation_r <= 1'b0;
    end else begin
      violation_r <= drop_s;
      if ((op_s == OP_WDATA) && (exec_s != 2'b00) && (wr_count_r != 16'hFFFF)) begin
        wr_count_r <= wr_count_r + 16'h0001;
      end
    end
  end

  // Read return path: cs1 half wins when both are selected
  always_comb begin
    rd_half_s   = ~graphic_lcd_cs1;
    rd_active_s = graphic_lcd_en & graphic_lcd_rw & (graphic_lcd_cs1 | graphic_lcd_cs2);
    status_s    = {busy_s[rd_half_s], 1'b0, ~on_r[rd_half_s], ~graphic_lcd_rst, 4'b0000};
    lcd_rd_oe   = rd_active_s & graphic_lcd_rst;
    if (!rd_active_s) begin
      lcd_rd_data = 8'h00;
    end else if (graphic_lcd_di) begin
      lcd_rd_data = latch_r[rd_half_s];
    end else begin
      lcd_rd_data = status_s;
    end
  end

  assign disp_on     = on_r;
  assign start_line0 = start_r[0];
  assign start_line1 = start_r[1];
  assign wr_count    = wr_count_r;
  assign violation   = violation_r;

endmodule

// File: tb/tb_lcd_panel_model.sv
// Directed self-checking bench for lcd_panel_model with BUSY_CYCLES = 4.
module tb_lcd_panel_model;

  logic        clk, rst;
  logic [7:0]  graphic_lcd_d;
  logic        graphic_lcd_rw, graphic_lcd_en, graphic_lcd_di, graphic_lcd_rst;
  logic        graphic_lcd_cs1, graphic_lcd_cs2;
  logic [7:0]  lcd_rd_data;
  logic        lcd_rd_oe;
  logic [9:0]  pix_addr;
  logic [7:0]  pix_data;
  logic [1:0]  disp_on;
  logic [5:0]  start_line0, start_line1;
  logic [15:0] wr_count;
  logic        violation;

  int checks = 0;
  int failures = 0;
  logic [7:0] rd;

  lcd_panel_model #(.BUSY_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .graphic_lcd_d(graphic_lcd_d), .graphic_lcd_rw(graphic_lcd_rw),
    .graphic_lcd_en(graphic_lcd_en), .graphic_lcd_di(graphic_lcd_di),
    .graphic_lcd_rst(graphic_lcd_rst),
    .graphic_lcd_cs1(graphic_lcd_cs1), .graphic_lcd_cs2(graphic_lcd_cs2),
    .lcd_rd_data(lcd_rd_data), .lcd_rd_oe(lcd_rd_oe),
    .pix_addr(pix_addr), .pix_data(pix_data),
    .disp_on(disp_on), .start_line0(start_line0), .start_line1(start_line1),
    .wr_count(wr_count), .violation(violation)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus transaction: en high for a cycle, then the strobe cycle; returns just after it
  task automatic xfer(input logic r, input logic dsel, input logic c1, input logic c2,
                      input logic [7:0] d, output logic [7:0] rdv);
    graphic_lcd_rw  = r;
    graphic_lcd_di  = dsel;
    graphic_lcd_cs1 = c1;
    graphic_lcd_cs2 = c2;
    graphic_lcd_d   = d;
    graphic_lcd_en  = 1'b1;
    #4 rdv = lcd_rd_data;
    @(posedge clk);
    #1 graphic_lcd_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_cmd(input logic c1, input logic c2, input logic [7:0] d);
    logic [7:0] dummy;
    xfer(1'b0, 1'b0, c1, c2, d, dummy);
    idle(3);
  endtask

  task automatic wr_dat(input logic c1, input logic c2, input logic [7:0] d);
    logic [7:0] dummy;
    xfer(1'b0, 1'b1, c1, c2, d, dummy);
    idle(3);
  endtask

  task automatic pix(input logic [9:0] a, output logic [7:0] v);
    pix_addr = a;
    @(posedge clk);
    #1 v = pix_data;
  endtask

  initial begin
    rst = 1'b1; graphic_lcd_en = 1'b0; graphic_lcd_rw = 1'b0; graphic_lcd_di = 1'b0;
    graphic_lcd_d = 8'h00; graphic_lcd_cs1 = 1'b0; graphic_lcd_cs2 = 1'b0;
    graphic_lcd_rst = 1'b1; pix_addr = 10'd0;
    idle(3);
    check("rst_oe", {15'd0, lcd_rd_oe}, 16'd0);
    check("rst_violation", {15'd0, violation}, 16'd0);
    rst = 1'b0;
    idle(1);
    check("rst_rd_data", {8'd0, lcd_rd_data}, 16'h0000);
    check("rst_disp_on", {14'd0, disp_on}, 16'd0);
    check("rst_start0", {10'd0, start_line0}, 16'd0);
    check("rst_start1", {10'd0, start_line1}, 16'd0);
    check("rst_wr_count", wr_count, 16'd0);

    // Left half: on, page 2, y 5, data A5
    wr_cmd(1'b1, 1'b0, 8'h3F);
    wr_cmd(1'b1, 1'b0, 8'hBA);
    wr_cmd(1'b1, 1'b0, 8'h45);
    wr_dat(1'b1, 1'b0, 8'hA5);
    pix({1'b0, 3'd2, 6'd5}, rd);
    check("t1_pix", {8'd0, rd}, 16'h00A5);
    check("t1_disp_on", {14'd0, disp_on}, 16'h0001);
    check("t1_wr_count", wr_count, 16'd1);

    // Right half: page 3, y wraps 63 -> 0 with page unchanged
    wr_cmd(1'b0, 1'b1, 8'hBB);
    wr_cmd(1'b0, 1'b1, 8'h7F);
    wr_dat(1'b0, 1'b1, 8'h11);
    wr_dat(1'b0, 1'b1, 8'h22);
    wr_dat(1'b0, 1'b1, 8'h33);
    pix({1'b1, 3'd3, 6'd63}, rd);
    check("t2_pix_y63", {8'd0, rd}, 16'h0011);
    pix({1'b1, 3'd3, 6'd0}, rd);
    check("t2_pix_y0", {8'd0, rd}, 16'h0022);
    pix({1'b1, 3'd3, 6'd1}, rd);
    check("t2_pix_y1_same_page", {8'd0, rd}, 16'h0033);
    check("t2_disp_on", {14'd0, disp_on}, 16'h0001);
    check("t2_wr_count", wr_count, 16'd4);

    // Both halves: start line 7 and one shared data byte
    wr_cmd(1'b1, 1'b1, 8'hC7);
    check("t3_start0", {10'd0, start_line0}, 16'd7);
    check("t3_start1", {10'd0, start_line1}, 16'd7);
    wr_dat(1'b1, 1'b1, 8'h5A);
    pix({1'b0, 3'd2, 6'd6}, rd);
    check("t3_pix_left", {8'd0, rd}, 16'h005A);
    pix({1'b1, 3'd3, 6'd2}, rd);
    check("t3_pix_right", {8'd0, rd}, 16'h005A);
    check("t3_wr_count", wr_count, 16'd5);

    // Busy window: second write two cycles after the strobe is dropped
    xfer(1'b0, 1'b1, 1'b1, 1'b0, 8'h77, rd);
    check("t4_no_violation_first", {15'd0, violation}, 16'd0);
    xfer(1'b0, 1'b1, 1'b1, 1'b0, 8'h88, rd);
    check("t4_violation_drop", {15'd0, violation}, 16'd1);
    xfer(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, rd);
    check("t4_status_busy", {8'd0, rd}, 16'h0080);
    check("t4_violation_cleared", {15'd0, violation}, 16'd0);
    xfer(1'b0, 1'b1, 1'b1, 1'b0, 8'h99, rd);
    check("t4_retry_accepted", {15'd0, violation}, 16'd0);
    idle(3);
    xfer(1'b0, 1'b1, 1'b1, 1'b0, 8'hAA, rd);
    check("t4_edge_accept", {15'd0, violation}, 16'd0);
    idle(2);
    xfer(1'b0, 1'b1, 1'b1, 1'b0, 8'hBB, rd);
    check("t4_edge_drop", {15'd0, violation}, 16'd1);
    idle(3);
    pix({1'b0, 3'd2, 6'd7}, rd);
    check("t4_pix_77", {8'd0, rd}, 16'h0077);
    pix({1'b0, 3'd2, 6'd8}, rd);
    check("t4_pix_99", {8'd0, rd}, 16'h0099);
    pix({1'b0, 3'd2, 6'd9}, rd);
    check("t4_pix_AA", {8'd0, rd}, 16'h00AA);
    check("t4_wr_count", wr_count, 16'd8);

    // Dummy read: first read after setting y returns the stale latch
    wr_cmd(1'b1, 1'b0, 8'h43);
    wr_dat(1'b1, 1'b0, 8'h3C);
    wr_cmd(1'b1, 1'b0, 8'h43);
    xfer(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, rd);
    check("t5_read_stale", {8'd0, rd}, 16'h0000);
    idle(3);
    xfer(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, rd);
    check("t5_read_data", {8'd0, rd}, 16'h003C);
    idle(3);
    wr_dat(1'b1, 1'b0, 8'h55);
    pix({1'b0, 3'd2, 6'd5}, rd);
    check("t5_final_y5", {8'd0, rd}, 16'h0055);
    check("t5_wr_count", wr_count, 16'd10);

    // Panel reset held low
    graphic_lcd_rst = 1'b0;
    idle(1);
    check("t6_disp_on", {14'd0, disp_on}, 16'd0);
    check("t6_start0", {10'd0, start_line0}, 16'd0);
    check("t6_start1", {10'd0, start_line1}, 16'd0);
    xfer(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, rd);
    check("t6_status", {8'd0, rd}, 16'h0030);
    wr_dat(1'b1, 1'b0, 8'hEE);
    check("t6_write_ignored", wr_count, 16'd10);
    graphic_lcd_rst = 1'b1;
    idle(1);
    wr_dat(1'b1, 1'b0, 8'h66);
    pix({1'b0, 3'd2, 6'd6}, rd);
    check("t6_after_release_pix", {8'd0, rd}, 16'h0066);
    check("t6_after_release_count", wr_count, 16'd11);

    // rst during a pending strobe, then en falling right after rst release
    graphic_lcd_rw = 1'b0; graphic_lcd_di = 1'b1; graphic_lcd_cs1 = 1'b1;
    graphic_lcd_cs2 = 1'b0; graphic_lcd_d = 8'h12; graphic_lcd_en = 1'b1;
    idle(1);
    rst = 1'b1; graphic_lcd_en = 1'b0;
    idle(1);
    graphic_lcd_en = 1'b1;
    idle(2);
    rst = 1'b0; graphic_lcd_en = 1'b0;
    idle(2);
    check("t7_wr_count", wr_count, 16'd0);
    check("t7_violation", {15'd0, violation}, 16'd0);
    pix({1'b0, 3'd2, 6'd7}, rd);
    check("t7_ram_kept", {8'd0, rd}, 16'h0077);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
